fact_mmio_unit: RTL

- Memory-mapped factorial accelerator on the core's data-memory side.
- Consumes the MEM-stage bus outputs: address (core ALU output), write enable and write data.
- Returns read data plus a hit flag. The SoC top muxes the read data into the core's data-read port.
- Computes n! iteratively for n = 0..12 with a busy/done/error status handshake.

---
 rtl/fact_mmio_pkg.sv | 20 ++
 rtl/fact_core_fsm.sv | 84 ++++++++
 rtl/fact_mmio_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fact_mmio_pkg.sv
// Shared definitions for the factorial MMIO accelerator.
//   fact_state_t  : core FSM state encoding (IDLE/BUSY/DONE)
//   OFF_*         : register word offsets within the 16-byte window (Addr[3:2])
//   MAX_N_DEFAULT : largest n whose factorial fits in 32 bits
package fact_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fact_state_t;

  localparam logic [1:0] OFF_N    = 2'd0;
  localparam logic [1:0] OFF_GO   = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_RES  = 2'd3;

  localparam int unsigned MAX_N_DEFAULT = 12;

endpackage

// File: rtl/fact_core_fsm.sv
// Iterative factorial engine: cnt/prod datapath plus IDLE/BUSY/DONE FSM.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : start request (ignored while busy)
//   n          : operand, sampled when a start is accepted
//   busy       : computation in progress
//   done, err  : completion status; err marks n > MAX_N
//   result     : last completed factorial (0 after an error)
//   finish     : combinational, high in the cycle whose edge raises done
module fact_core_fsm
  import fact_mmio_pkg::*;
#(
  parameter int unsigned MAX_N = MAX_N_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        finish,
  output logic [31:0] result
);

  fact_state_t state;
  logic [3:0]  cnt;
  logic [31:0] prod;
  logic        accept;
  logic        too_big;

  assign accept  = start && (state != BUSY);
  assign too_big = 32'(n) > MAX_N;
  // Completion happens either on an error accept or on the last BUSY step.
  assign finish  = (accept && too_big) || ((state == BUSY) && (cnt <= 4'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= 32'd1;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (too_big) begin
              err    <= 1'b1;
              done   <= 1'b1;
              result <= '0;
              state  <= DONE;
            end else begin
              cnt   <= n;
              prod  <= 32'd1;
              done  <= 1'b0;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt <= 4'd1) begin
            result <= prod;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            prod <= prod * 32'(cnt);
            cnt  <= cnt - 4'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/fact_mmio_unit.sv
// Memory-mapped factorial accelerator on the core's data-memory bus.
// Register window (16 bytes at BASE_ADDR, word offset Addr[3:2]):
//   0 N_REG  RW  bits[3:0] = n
//   1 GO     W bit0 = start, R {31'b0, busy}
//   2 STATUS RO  {30'b0, err, done}
//   3 RESULT RO
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   Addr, WE, WD : MEM-stage byte address, write enable, write data
//   Hit      : combinational window decode
//   RD       : combinational read data, 0 outside the window
//   IRQ      : sticky done interrupt when FACT_MMIO_IRQ_EN is defined,
//              otherwise tied 0
module fact_mmio_unit
  import fact_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
  parameter int unsigned MAX_N     = MAX_N_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic        Hit,
  output logic [31:0] RD,
  output logic        IRQ
);

  logic [3:0]  n_reg;
  logic [1:0]  off;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        finish;
  logic [31:0] result;

  assign Hit   = (Addr[31:4] == BASE_ADDR[31:4]);
  assign off   = Addr[3:2];
  assign start = WE && Hit && (off == OFF_GO) && WD[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_reg <= '0;
    end else if (WE && Hit && (off == OFF_N)) begin
      n_reg <= WD[3:0];
    end
  end

  fact_core_fsm #(
    .MAX_N (MAX_N)
  ) u_core (
    .clk    (CLK),
    .rst    (RST),
    .start  (start),
    .n      (n_reg),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .finish (finish),
    .result (result)
  );

  always_comb begin
    RD = '0;
    if (Hit) begin
      case (off)
        OFF_N:    RD = {28'b0, n_reg};
        OFF_GO:   RD = {31'b0, busy};
        OFF_STAT: RD = {30'b0, err, done};
        OFF_RES:  RD = result;
        default:  RD = '0;
      endcase
    end
  end

`ifdef FACT_MMIO_IRQ_EN
  logic irq_q;
  logic stat_read;
  logic go_accept;

  assign stat_read = Hit && !WE && (off == OFF_STAT);
  assign go_accept = start && !busy;

  // Set wins over clear, so an error accept (which is also a GO) raises IRQ.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_q <= 1'b0;
    end else if (finish) begin
      irq_q <= 1'b1;
    end else if (stat_read || go_accept) begin
      irq_q <= 1'b0;
    end
  end

  assign IRQ = irq_q;

  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], WD[31:4]};
`else
  assign IRQ = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], WD[31:4], finish};
`endif

endmodule
